// File: rtl/prog_ram_arbiter_pkg.sv
// Shared types and default widths for the program RAM arbiter.
// Widths match the CPU's 16x8 program RAM and its 4-bit MAR.
package prog_ram_arbiter_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        CPU_OWN = 2'd0,
        DRAIN   = 2'd1,
        LD_OWN  = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/prog_ram_arbiter_burst_counter.sv
// Counts accepted loader transfers within one tenure.
// last is high on the increment that completes the MAX_BURST-th transfer.
module burst_counter #(
    parameter int MAX_BURST = 16,
    parameter int CNT_W     = $clog2(MAX_BURST) + 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic last
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (inc)
            count <= count + 1'b1;
    end

    assign last = inc && (count == CNT_W'(MAX_BURST - 1));

endmodule

// File: rtl/prog_ram_arbiter.sv
// Arbitrates the program RAM between the CPU control path and a loader port.
// The CPU is parked at an instruction boundary before the loader gets the RAM.
module prog_ram_arbiter
    import prog_ram_arbiter_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_ram_we,
    input  logic              cpu_ram_re,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_boundary,
    output logic              cpu_hold,
    input  logic              ld_req,
    output logic              ld_gnt,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_rvalid,
    output logic              ram_we,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    arb_state_t        state_q, state_d;
    logic              lockout, seen_low;
    logic              accept, burst_last, burst_clear;
    logic [DATA_W-1:0] rdata_q;

    assign accept      = (state_q == LD_OWN) && ld_valid;
    assign burst_clear = (state_d == LD_OWN) && (state_q != LD_OWN);

    burst_counter #(.MAX_BURST(MAX_BURST)) u_burst_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (burst_clear),
        .inc   (accept),
        .last  (burst_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= CPU_OWN;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            CPU_OWN: if (ld_req && !lockout) state_d = cpu_boundary ? LD_OWN : DRAIN;
            DRAIN: begin
                if (!ld_req)
                    state_d = CPU_OWN;
                else if (cpu_boundary)
                    state_d = LD_OWN;
            end
            LD_OWN:  if (burst_last || !ld_req) state_d = RELEASE;
            RELEASE: state_d = CPU_OWN;
            default: state_d = CPU_OWN;
        endcase
    end

    // Lockout holds off re-grant until the CPU leaves fetch1 and returns,
    // i.e. it has retired at least one instruction since the last tenure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lockout  <= 1'b0;
            seen_low <= 1'b0;
        end else if (state_q == RELEASE) begin
            lockout  <= 1'b1;
            seen_low <= 1'b0;
        end else if (lockout) begin
            if (!cpu_boundary)
                seen_low <= 1'b1;
            else if (seen_low)
                lockout <= 1'b0;
        end
    end

    assign cpu_hold = (state_q == DRAIN) || (state_q == LD_OWN);
    assign ld_gnt   = (state_q == LD_OWN);
    assign ld_ready = (state_q == LD_OWN);

    always_comb begin
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        case (state_q)
            CPU_OWN, DRAIN: begin
                ram_we    = cpu_ram_we;
                ram_re    = cpu_ram_re;
                ram_addr  = cpu_addr;
                ram_wdata = cpu_wdata;
            end
            LD_OWN: begin
                ram_we    = accept && ld_we;
                ram_re    = accept && !ld_we;
                ram_addr  = ld_addr;
                ram_wdata = ld_wdata;
            end
            default: ;
        endcase
    end

    // RAM read data arrives the cycle after the strobe; forward it during the
    // rvalid pulse and hold the captured copy afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_rvalid <= 1'b0;
            rdata_q   <= '0;
        end else begin
            ld_rvalid <= accept && !ld_we;
            if (ld_rvalid)
                rdata_q <= ram_rdata;
        end
    end

    assign ld_rdata = ld_rvalid ? ram_rdata : rdata_q;

endmodule

// File: tb/tb_prog_ram_arbiter.sv
// Directed bench for prog_ram_arbiter with a small synchronous RAM model.
module tb_prog_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_ram_we, cpu_ram_re, cpu_boundary, cpu_hold;
    logic [3:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic       ld_req, ld_gnt, ld_valid, ld_ready, ld_we, ld_rvalid;
    logic [3:0] ld_addr;
    logic [7:0] ld_wdata, ld_rdata;
    logic       ram_we, ram_re;
    logic [3:0] ram_addr;
    logic [7:0] ram_wdata, ram_rdata;

    logic [7:0] mem [16];
    int n_cmp = 0;
    int n_bad = 0;
    int accepts;

    always #5 clk = ~clk;

    prog_ram_arbiter #(.ADDR_W(4), .DATA_W(8), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_ram_we(cpu_ram_we), .cpu_ram_re(cpu_ram_re), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_boundary(cpu_boundary), .cpu_hold(cpu_hold),
        .ld_req(ld_req), .ld_gnt(ld_gnt), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_rdata(ld_rdata),
        .ld_rvalid(ld_rvalid), .ram_we(ram_we), .ram_re(ram_re), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    initial for (int i = 0; i < 16; i++) mem[i] = 8'h00;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        cpu_ram_we = 0; cpu_ram_re = 0; cpu_addr = 0; cpu_wdata = 0; cpu_boundary = 0;
        ld_req = 0; ld_valid = 0; ld_we = 0; ld_addr = 0; ld_wdata = 0;
        ram_rdata = 8'h00;
        #3;
        chk("rst_hold", cpu_hold, 0);
        chk("rst_gnt", ld_gnt, 0);
        chk("rst_ready", ld_ready, 0);
        chk("rst_rvalid", ld_rvalid, 0);
        chk("rst_rdata", ld_rdata, 0);
        cyc();
        rst = 1'b0;

        // Loader valid without request: RAM follows the CPU only
        ld_valid = 1; ld_we = 1; ld_addr = 4'd3; ld_wdata = 8'h77;
        cpu_ram_re = 1; cpu_addr = 4'd5;
        mid();
        chk("noreq_ready", ld_ready, 0);
        chk("noreq_we", ram_we, 0);
        chk("noreq_re", ram_re, 1);
        chk("noreq_addr", ram_addr, 5);
        cyc();
        ld_valid = 0; cpu_ram_re = 0;

        // Request at boundary: straight to LD_OWN, no drain
        cpu_boundary = 1; ld_req = 1;
        mid();
        chk("direct_pre_gnt", ld_gnt, 0);
        cyc();
        chk("direct_gnt", ld_gnt, 1);
        chk("direct_hold", cpu_hold, 1);
        chk("direct_ready", ld_ready, 1);

        // Write 0xA5 to addr 3 while CPU tries to store elsewhere
        ld_valid = 1; ld_we = 1; ld_addr = 4'd3; ld_wdata = 8'hA5;
        cpu_ram_we = 1; cpu_addr = 4'd9; cpu_wdata = 8'h11;
        mid();
        chk("wr_we", ram_we, 1);
        chk("wr_addr", ram_addr, 3);
        chk("wr_data", ram_wdata, 8'hA5);
        cyc();
        ld_we = 0;
        mid();
        chk("rd_re", ram_re, 1);
        chk("rd_cpu_masked", ram_we, 0);
        cyc();
        ld_valid = 0;
        mid();
        chk("rd_rvalid", ld_rvalid, 1);
        chk("rd_rdata", ld_rdata, 8'hA5);
        cyc();
        chk("rd_rvalid_pulse", ld_rvalid, 0);
        chk("rd_rdata_hold", ld_rdata, 8'hA5);

        // Loader drops request -> RELEASE then CPU_OWN
        ld_req = 0;
        mid();
        chk("drop_gnt_still", ld_gnt, 1);
        cyc();
        chk("rel_gnt", ld_gnt, 0);
        chk("rel_hold", cpu_hold, 0);
        chk("rel_we", ram_we, 0);
        cyc();
        chk("cpu_back_we", ram_we, 1);
        cpu_ram_we = 0;

        // Lockout: no re-grant until boundary toggles low then high
        ld_req = 1;
        cyc();
        chk("lock_gnt", ld_gnt, 0);
        chk("lock_hold", cpu_hold, 0);
        cpu_boundary = 0;
        cyc();
        chk("lock_low_hold", cpu_hold, 0);
        cpu_boundary = 1;
        cyc();
        chk("lock_clear_edge", ld_gnt, 0);
        cyc();
        chk("regrant_gnt", ld_gnt, 1);

        // Burst limit 4: valid held 6 cycles
        ld_valid = 1; ld_we = 1; accepts = 0;
        for (int i = 0; i < 6; i++) begin
            ld_addr = 4'(i); ld_wdata = 8'(8'h30 + i);
            mid();
            if (ld_valid && ld_ready) accepts++;
            cyc();
        end
        chk("burst_accepts", accepts, 4);
        chk("burst_gnt_after", ld_gnt, 0);
        chk("burst_mem3", mem[3], 8'h33);
        cyc();
        chk("burst_no_regrant", ld_gnt, 0);
        ld_valid = 0; ld_req = 0;

        // Clear lockout, then request mid-instruction -> DRAIN
        cpu_boundary = 0;
        cyc();
        cpu_boundary = 1;
        cyc();
        cpu_boundary = 0; cpu_ram_re = 1; cpu_addr = 4'd7; ld_req = 1;
        cyc();
        chk("drain_hold", cpu_hold, 1);
        chk("drain_gnt", ld_gnt, 0);
        chk("drain_cpu_re", ram_re, 1);
        cyc();
        chk("drain_wait_hold", cpu_hold, 1);
        chk("drain_wait_gnt", ld_gnt, 0);
        cpu_boundary = 1; cpu_ram_re = 0; cpu_ram_we = 1;
        cyc();
        chk("drain_gnt_up", ld_gnt, 1);
        chk("drain_cpu_masked", ram_we, 0);

        // Reset with a read accepted in the same cycle: no rvalid afterwards
        ld_valid = 1; ld_we = 0; ld_addr = 4'd3;
        mid();
        chk("inflight_re", ram_re, 1);
        #1 rst = 1;
        #1;
        chk("rstmid_hold", cpu_hold, 0);
        chk("rstmid_gnt", ld_gnt, 0);
        cyc();
        chk("rstmid_rvalid", ld_rvalid, 0);
        chk("rstmid_rdata", ld_rdata, 0);
        ld_valid = 0; cpu_ram_we = 0;
        rst = 0;
        cyc();
        chk("post_rst_gnt", ld_gnt, 1);
        ld_req = 0;
        cyc();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
